if_id_stall_ctrl: RTL and testbench
===================================

// Module: if_id_stall_ctrl
// PURPOSE
//   Consumer of the hazard unit's FlushSignal and of the decode-stage branch/jump resolve.
//   Owns the IF/ID pipeline register and the PC write-enable, and drives the ID bubble select
//   that zeroes ID/EX control signals.
//   Sits between fetch and decode in the 5-stage pipeline.
//   Also keeps a stall watchdog and saturating stall/squash counters for debug.
// PARAMETERS
//   DATA_W     32  width of instruction and PC+4 paths
//   MAX_STALL  2   max legal consecutive stall cycles; the hazard window is ID/EX plus EX/MEM
//   CNT_W      16  width of each performance counter
// PORTS
//   Clk               in   1       pipeline clock; all state updates on rising edge
//   Reset             in   1       synchronous, active-high reset
//   FlushSignal       in   1       stall request from hazard unit (1 = hold IF/ID, bubble ID/EX)
//   BranchTaken       in   1       branch resolved taken in ID this cycle
//   Jump              in   1       jump decoded in ID this cycle
//   IF_Instruction    in   DATA_W  fetched instruction
//   IF_PCPlus4        in   DATA_W  fetched PC+4
//   PCWrite           out  1       PC register enable
//   IF_ID_Instruction out  DATA_W  registered instruction to decode
//   IF_ID_PCPlus4     out  DATA_W  registered PC+4 to decode
//   IF_ID_Valid       out  1       1 = IF/ID holds a real instruction; 0 = squashed or reset bubble
//   ID_Bubble         out  1       1 = ID/EX control mux selects all-zero (nop) controls
//   StallTimeout      out  1       sticky error: stall exceeded MAX_STALL consecutive cycles
//   StallCount        out  CNT_W   saturating count of stall cycles
//   SquashCount       out  CNT_W   saturating count of squashed fetch slots
// BEHAVIOUR
//   Reset values (Reset high at the edge):
//     IF_ID_Instruction = 0 (sll $0 nop); IF_ID_PCPlus4 = 0; IF_ID_Valid = 0.
//     Counters = 0; StallTimeout = 0; state = RUN; stall run length = 0.
//   While Reset is high: PCWrite = 0 and ID_Bubble = 1. Reset mid-stall discards the stall immediately.
//   Redirect = (BranchTaken | Jump) & ~FlushSignal.
//   Stall wins over redirect: branch operands are not ready, so the decode stage re-asserts later.
//   Combinational outputs, zero-latency in the same cycle: PCWrite = ~FlushSignal; ID_Bubble = FlushSignal.
//   IF/ID update, one edge later:
//     FlushSignal=1          -> hold IF/ID contents and IF_ID_Valid.
//     Redirect=1             -> load nop, IF_ID_Valid = 0 (squash the wrong-path fetch, no delay slot).
//     else                   -> load IF_Instruction / IF_PCPlus4, IF_ID_Valid = 1.
//   FSM (2-bit):
//     RUN    -> STALL  on FlushSignal; RUN -> SQUASH on Redirect; otherwise stay in RUN.
//     STALL  -> STALL while FlushSignal; otherwise -> SQUASH if Redirect, else -> RUN.
//     SQUASH -> STALL on FlushSignal; SQUASH on Redirect (back-to-back jumps); otherwise RUN.
//     SQUASH means IF/ID currently holds a squashed slot.
//     With IF_ID_Valid=0, decode must treat BranchTaken/Jump as 0.
//     Any assertion of either input while IF_ID_Valid=0 is a protocol error and is ignored (no redirect).
//   Watchdog:
//     Run length increments each FlushSignal cycle and clears on the first cycle without it.
//     When the run length reaches MAX_STALL+1, StallTimeout sets and stays set until Reset.
//   Counters:
//     StallCount += 1 per FlushSignal cycle.
//     SquashCount += 1 per accepted Redirect.
//     Both saturate at all-ones and never wrap.
// STRUCTURE
//   Shared package pipe_pkg:
//     NOP_INSTR = 32'h0000_0000.
//     State encodings RUN=2'd0, STALL=2'd1, SQUASH=2'd2; 2'd3 is illegal and recovers to RUN.
//   One sub-module, if_id_reg: DATA_W-wide register pair plus a valid bit, with Enable and Clear.
//     Clear has priority over Enable; Reset is equivalent to Clear.
//   Top level holds the FSM, watchdog and counters.
// TESTING
//   1. Reset 3 cycles, then run 4 fetches with no hazards.
//      -> PCWrite=1 throughout; each IF/ID value appears 1 cycle later; Valid=1 from the first fetch.
//   2. FlushSignal high for 2 cycles with IF_Instruction=32'h8C08_0004.
//      -> PCWrite=0 and ID_Bubble=1 for 2 cycles; IF/ID holds its prior value.
//      -> StallCount=2; StallTimeout stays 0.
//   3. BranchTaken=1 for 1 cycle.
//      -> next edge IF_ID_Instruction=0 and Valid=0; SquashCount=1; state SQUASH, then RUN.
//   4. FlushSignal=1 and Jump=1 in the same cycle.
//      -> stall only; SquashCount unchanged; state STALL.
//   5. FlushSignal held 3 cycles with MAX_STALL=2.
//      -> StallTimeout=1 at the 3rd edge and stays 1 after FlushSignal drops, until Reset.
//   6. Reset asserted in the middle of a stall.
//      -> next edge: all outputs at reset values; StallCount=0.
//   7. Force StallCount to 16'hFFFE, then stall 3 cycles.
//      -> StallCount holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: nop encoding and IF/ID control state codes.
// State codes are plain 2-bit constants so existing decode/debug logic keeps its encoding.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] STALL  = 2'd1;
   localparam logic [1:0] SQUASH = 2'd2;

   // redirect is already masked by stall, so stall naturally wins; 2'd3 falls back to RUN
   function automatic logic [1:0] nextState(input logic [1:0] cur,
                                             input logic       stall,
                                             input logic       redirect);
      logic [1:0] nxt;
      nxt = RUN;
      case (cur)
         RUN, STALL, SQUASH: begin
            if (stall)
               nxt = STALL;
            else if (redirect)
               nxt = SQUASH;
            else
               nxt = RUN;
         end
         default: nxt = RUN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and a valid bit.
// Clear (or Reset) loads a nop bubble and overrides Enable.
module if_id_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Clear,
   input  logic              Enable,
   input  logic [DATA_W-1:0] InstrIn,
   input  logic [DATA_W-1:0] PcPlus4In,
   output logic [DATA_W-1:0] Instr,
   output logic [DATA_W-1:0] PcPlus4,
   output logic              Valid
);

   always_ff @(posedge Clk) begin
      if (Reset || Clear) begin
         Instr   <= DATA_W'(NOP_INSTR);
         PcPlus4 <= '0;
         Valid   <= 1'b0;
      end else if (Enable) begin
         Instr   <= InstrIn;
         PcPlus4 <= PcPlus4In;
         Valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID stall/squash control: owns the IF/ID register, PC enable and ID bubble select,
// plus a sticky stall watchdog and saturating debug counters.
module if_id_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_STALL = 2,
   parameter int CNT_W     = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              FlushSignal,
   input  logic              BranchTaken,
   input  logic              Jump,
   input  logic [DATA_W-1:0] IF_Instruction,
   input  logic [DATA_W-1:0] IF_PCPlus4,
   output logic              PCWrite,
   output logic [DATA_W-1:0] IF_ID_Instruction,
   output logic [DATA_W-1:0] IF_ID_PCPlus4,
   output logic              IF_ID_Valid,
   output logic              ID_Bubble,
   output logic              StallTimeout,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  SquashCount
);

   localparam int RUN_W = $clog2(MAX_STALL + 2);
   localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(MAX_STALL + 1);
   localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(MAX_STALL);

   logic [1:0]       state;
   logic [RUN_W-1:0] stallRun;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] squashCnt;
   logic             redirect;

   // a branch/jump seen while IF/ID holds a bubble is a protocol error and is ignored
   assign redirect  = (BranchTaken | Jump) & ~FlushSignal & IF_ID_Valid;
   assign PCWrite   = ~FlushSignal & ~Reset;
   assign ID_Bubble = FlushSignal | Reset;

   assign StallCount  = stallCnt;
   assign SquashCount = squashCnt;

   if_id_reg #(.DATA_W(DATA_W)) uIfIdReg (
      .Clk      (Clk),
      .Reset    (Reset),
      .Clear    (redirect),
      .Enable   (~FlushSignal),
      .InstrIn  (IF_Instruction),
      .PcPlus4In(IF_PCPlus4),
      .Instr    (IF_ID_Instruction),
      .PcPlus4  (IF_ID_PCPlus4),
      .Valid    (IF_ID_Valid)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= RUN;
         stallRun     <= '0;
         StallTimeout <= 1'b0;
         stallCnt     <= '0;
         squashCnt    <= '0;
      end else begin
         state <= nextState(state, FlushSignal, redirect);
         if (FlushSignal) begin
            if (stallRun != RUN_SAT)
               stallRun <= stallRun + RUN_W'(1);
            // this edge brings the run length to MAX_STALL+1
            if (stallRun >= RUN_TRIP)
               StallTimeout <= 1'b1;
            if (stallCnt != '1)
               stallCnt <= stallCnt + CNT_W'(1);
         end else begin
            stallRun <= '0;
         end
         if (redirect && squashCnt != '1)
            squashCnt <= squashCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Self-checking bench for if_id_stall_ctrl: directed vector table, hand-written
// watchdog/reset/saturation sequences and random stimulus against a reference model.
module tb_if_id_stall_ctrl;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int MS = 2;
   localparam int CW = 16;

   logic          Clk = 1'b0;
   logic          Reset, FlushSignal, BranchTaken, Jump;
   logic [DW-1:0] IF_Instruction, IF_PCPlus4;
   logic          PCWrite, IF_ID_Valid, ID_Bubble, StallTimeout;
   logic [DW-1:0] IF_ID_Instruction, IF_ID_PCPlus4;
   logic [CW-1:0] StallCount, SquashCount;

   always #5 Clk = ~Clk;

   if_id_stall_ctrl #(.DATA_W(DW), .MAX_STALL(MS), .CNT_W(CW)) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .FlushSignal      (FlushSignal),
      .BranchTaken      (BranchTaken),
      .Jump             (Jump),
      .IF_Instruction   (IF_Instruction),
      .IF_PCPlus4       (IF_PCPlus4),
      .PCWrite          (PCWrite),
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_PCPlus4    (IF_ID_PCPlus4),
      .IF_ID_Valid      (IF_ID_Valid),
      .ID_Bubble        (ID_Bubble),
      .StallTimeout     (StallTimeout),
      .StallCount       (StallCount),
      .SquashCount      (SquashCount)
   );

   int passCnt = 0;
   int totCnt  = 0;

   // reference model of the architecturally visible state
   logic [31:0] mInstr = '0, mPc = '0;
   bit          mValid = 0, mTo = 0;
   int          mRun = 0, mStall = 0, mSquash = 0;

   typedef struct {
      bit          rst, f, b, j;
      logic [31:0] ins, pc;
      bit          ePcw, eBub;
      logic [31:0] eIns, ePc;
      bit          eVal;
      logic [1:0]  eSt;
      int          eStall, eSquash;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      totCnt++;
      if (act === exp)
         passCnt++;
      else
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // one clock: drive, check combinational outputs, clock, advance model, check registers
   task automatic step(input bit rst, input bit f, input bit b, input bit j,
                       input logic [31:0] ins, input logic [31:0] pc,
                       output bit pcwS, output bit bubS);
      bit redir;
      @(negedge Clk);
      Reset = rst; FlushSignal = f; BranchTaken = b; Jump = j;
      IF_Instruction = ins; IF_PCPlus4 = pc;
      #1;
      pcwS = PCWrite; bubS = ID_Bubble;
      chk("PCWrite", 64'(PCWrite), 64'(!rst && !f));
      chk("ID_Bubble", 64'(ID_Bubble), 64'(rst || f));
      @(posedge Clk);
      if (rst) begin
         mInstr = '0; mPc = '0; mValid = 0; mTo = 0;
         mRun = 0; mStall = 0; mSquash = 0;
      end else begin
         redir = (b || j) && !f && mValid;
         if (f) begin
            mRun++;
            if (mRun > MS) mTo = 1;
            if (mStall < 65535) mStall++;
         end else begin
            mRun = 0;
         end
         if (redir) begin
            if (mSquash < 65535) mSquash++;
            mInstr = '0; mPc = '0; mValid = 0;
         end else if (!f) begin
            mInstr = ins; mPc = pc; mValid = 1;
         end
      end
      #1;
      chk("IF_ID_Instruction", 64'(IF_ID_Instruction), 64'(mInstr));
      chk("IF_ID_PCPlus4", 64'(IF_ID_PCPlus4), 64'(mPc));
      chk("IF_ID_Valid", 64'(IF_ID_Valid), 64'(mValid));
      chk("StallTimeout", 64'(StallTimeout), 64'(mTo));
      chk("StallCount", 64'(StallCount), 64'(mStall));
      chk("SquashCount", 64'(SquashCount), 64'(mSquash));
   endtask

   initial begin
      bit pcwS, bubS;
      Reset = 1; FlushSignal = 0; BranchTaken = 0; Jump = 0;
      IF_Instruction = '0; IF_PCPlus4 = '0;

      for (int i = 0; i < 3; i++)
         tbl.push_back('{1,0,0,0, 32'h0, 32'h0, 0,1, 32'h0, 32'h0, 0, RUN, 0, 0});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{0,0,0,0, 32'h2001_0001 + i, 32'(4*(i+1)), 1,0,
                         32'h2001_0001 + i, 32'(4*(i+1)), 1, RUN, 0, 0});
      tbl.push_back('{0,1,0,0, 32'h8C08_0004, 32'd20, 0,1, 32'h2001_0004, 32'd16, 1, STALL, 1, 0});
      tbl.push_back('{0,1,0,0, 32'h8C08_0004, 32'd20, 0,1, 32'h2001_0004, 32'd16, 1, STALL, 2, 0});
      tbl.push_back('{0,0,1,0, 32'h8C08_0004, 32'd20, 1,0, 32'h0, 32'h0, 0, SQUASH, 2, 1});
      tbl.push_back('{0,0,1,0, 32'h8C08_0004, 32'd24, 1,0, 32'h8C08_0004, 32'd24, 1, RUN, 2, 1});
      tbl.push_back('{0,1,0,1, 32'hDEAD_BEEF, 32'd28, 0,1, 32'h8C08_0004, 32'd24, 1, STALL, 3, 1});
      tbl.push_back('{0,0,0,0, 32'hAAAA_0001, 32'd28, 1,0, 32'hAAAA_0001, 32'd28, 1, RUN, 3, 1});
      tbl.push_back('{0,0,0,1, 32'hBBBB_0002, 32'd32, 1,0, 32'h0, 32'h0, 0, SQUASH, 3, 2});
      tbl.push_back('{0,0,0,0, 32'hCCCC_0003, 32'd36, 1,0, 32'hCCCC_0003, 32'd36, 1, RUN, 3, 2});

      foreach (tbl[k]) begin
         step(tbl[k].rst, tbl[k].f, tbl[k].b, tbl[k].j, tbl[k].ins, tbl[k].pc, pcwS, bubS);
         chk("vec.PCWrite", 64'(pcwS), 64'(tbl[k].ePcw));
         chk("vec.ID_Bubble", 64'(bubS), 64'(tbl[k].eBub));
         chk("vec.Instr", 64'(IF_ID_Instruction), 64'(tbl[k].eIns));
         chk("vec.PCPlus4", 64'(IF_ID_PCPlus4), 64'(tbl[k].ePc));
         chk("vec.Valid", 64'(IF_ID_Valid), 64'(tbl[k].eVal));
         chk("vec.state", 64'(dut.state), 64'(tbl[k].eSt));
         chk("vec.StallCount", 64'(StallCount), 64'(tbl[k].eStall));
         chk("vec.SquashCount", 64'(SquashCount), 64'(tbl[k].eSquash));
         chk("vec.StallTimeout", 64'(StallTimeout), 64'd0);
      end

      // watchdog: third consecutive stall edge trips it, and it stays set
      step(0,1,0,0, 32'h1111_0000, 32'd40, pcwS, bubS);
      chk("wd.edge1", 64'(StallTimeout), 64'd0);
      step(0,1,0,0, 32'h1111_0000, 32'd40, pcwS, bubS);
      chk("wd.edge2", 64'(StallTimeout), 64'd0);
      step(0,1,0,0, 32'h1111_0000, 32'd40, pcwS, bubS);
      chk("wd.edge3", 64'(StallTimeout), 64'd1);
      step(0,0,0,0, 32'h1111_0000, 32'd40, pcwS, bubS);
      step(0,0,0,0, 32'h2222_0000, 32'd44, pcwS, bubS);
      chk("wd.sticky", 64'(StallTimeout), 64'd1);

      // reset in the middle of a stall
      step(0,1,0,0, 32'h3333_0000, 32'd48, pcwS, bubS);
      step(1,1,0,0, 32'h3333_0000, 32'd48, pcwS, bubS);
      chk("rst.PCWrite", 64'(pcwS), 64'd0);
      chk("rst.ID_Bubble", 64'(bubS), 64'd1);
      chk("rst.StallCount", 64'(StallCount), 64'd0);
      chk("rst.StallTimeout", 64'(StallTimeout), 64'd0);
      chk("rst.Valid", 64'(IF_ID_Valid), 64'd0);
      chk("rst.state", 64'(dut.state), 64'(RUN));
      step(0,0,0,0, 32'h4444_0000, 32'd52, pcwS, bubS);

      // counter saturation from a preloaded value
      force dut.stallCnt = 16'hFFFE;
      #1;
      release dut.stallCnt;
      mStall = 32'hFFFE;
      for (int i = 0; i < 3; i++)
         step(0,1,0,0, 32'h5555_0000, 32'd56, pcwS, bubS);
      chk("sat.StallCount", 64'(StallCount), 64'hFFFF);

      // random traffic against the model
      step(1,0,0,0, 32'h0, 32'h0, pcwS, bubS);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom, $urandom, pcwS, bubS);

      $display("%0d/%0d checks passed", passCnt, totCnt);
      $finish;
   end

endmodule
